conv_ctrl: RTL

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_pkg.sv | 34 +++
 rtl/sig_delay.sv | 33 +++
 rtl/conv_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: constants and types shared by the convolution controller.
//   state_e         - controller FSM encoding (IDLE / RUN / DRAIN)
//   DEF_*           - default parameter values of conv_ctrl
//   DEF_ACC_DELAY   - default kernel_start -> final accumulated value latency
//   cnt_w()         - register width needed for a 0..n-1 counter
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_DW           = 32;
    localparam int DEF_K            = 3;
    localparam int DEF_OUT_H        = 2;
    localparam int DEF_OUT_W        = 2;
    localparam int DEF_AW           = 10;
    localparam int DEF_WAW          = 4;
    localparam int DEF_MEM_DELAY    = 1;
    localparam int DEF_FP_ADD_DELAY = 14;
    localparam int FP_MUL_DELAY     = 8;
    localparam int FP_ACCUM_DELAY   = 12;

    // Buffer read, multiply, two adder passes, pipeline glue, K*K products
    // streaming into the accumulator and its drain.
    localparam int DEF_ACC_DELAY = DEF_MEM_DELAY + FP_MUL_DELAY + 2 * DEF_FP_ADD_DELAY
                                 + 3 + DEF_K * DEF_K + FP_ACCUM_DELAY - 1;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// sig_delay: fixed-latency delay line for a single-bit pulse.
//   clk_i    - clock, rising edge
//   rst_n_i  - synchronous active-low reset, clears every stage
//   d_i      - pulse in
//   q_o      - d_i delayed by DELAY cycles (DELAY=0 is a wire)
module sig_delay #(
    parameter int DELAY = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    if (DELAY == 0) begin : g_wire
        assign q_o = d_i;
    end else if (DELAY == 1) begin : g_one
        logic sr_q;
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) sr_q <= 1'b0;
            else          sr_q <= d_i;
        end
        assign q_o = sr_q;
    end else begin : g_shift
        logic [DELAY-1:0] sr_q;
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) sr_q <= '0;
            else          sr_q <= {sr_q[DELAY-2:0], d_i};
        end
        assign q_o = sr_q[DELAY-1];
    end

endmodule

// File: rtl/conv_ctrl.sv
// conv_ctrl: address/timing controller for one convolution output tile.
// Walks r, c (output pixel) and i, j (kernel tap) one tap per cycle, issuing
// in_fm and weight reads, then schedules the accumulator restart, the
// partial-output read and the updated-output write of every pixel.
//   clk, rst (sync, active-low)
//   start                          - one-cycle tile request (ignored while busy)
//   busy, done                     - tile in flight / one-cycle completion pulse
//   in_fm_rd_ena/addr              - input feature map read
//   weight_rd_ena/addr             - weight read
//   kernel_start                   - accumulator restart pulse
//   out_fm_rd_ena/addr             - partial output read
//   out_fm_wr_ena/addr             - updated output write
module conv_ctrl
    import conv_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int K            = DEF_K,
    parameter int OUT_H        = DEF_OUT_H,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int IN_W         = OUT_W + K - 1,
    parameter int AW           = DEF_AW,
    parameter int WAW          = DEF_WAW,
    parameter int MEM_DELAY    = DEF_MEM_DELAY,
    parameter int ACC_DELAY    = DEF_ACC_DELAY,
    parameter int FP_ADD_DELAY = DEF_FP_ADD_DELAY
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           in_fm_rd_ena,
    output logic [AW-1:0]  in_fm_rd_addr,
    output logic           weight_rd_ena,
    output logic [WAW-1:0] weight_rd_addr,
    output logic           kernel_start,
    output logic           out_fm_rd_ena,
    output logic [AW-1:0]  out_fm_rd_addr,
    output logic           out_fm_wr_ena,
    output logic [AW-1:0]  out_fm_wr_addr
);

    localparam int RW   = cnt_w(OUT_H);
    localparam int CW   = cnt_w(OUT_W);
    localparam int KW   = cnt_w(K);
    localparam int NPIX = OUT_H * OUT_W;

    // DW only sizes the datapath words; it is sanity-checked here alongside
    // the schedule, which needs the partial read to follow kernel_start.
    if (DW < 1 || ACC_DELAY <= MEM_DELAY || NPIX > (1 << AW)) begin : g_bad_params
        $error("conv_ctrl: inconsistent parameters");
    end

    state_e         state_q, state_d;
    logic [RW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [KW-1:0]  i_q, i_d, j_q, j_d;
    logic [AW-1:0]  rd_pix_q, rd_pix_d;
    logic [AW-1:0]  wr_pix_q, wr_pix_d;
    logic           done_q, done_d;

    logic           last_addr;
    logic           ks_src;
    logic           rd_pulse;
    logic           wr_pulse;
    logic           wr_last;

    // Tap/pixel counters: j innermost, r outermost, each wrapping and carrying.
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        i_d = i_q;
        j_d = j_q;
        if (state_q == ST_RUN) begin
            if (j_q == KW'(K - 1)) begin
                j_d = '0;
                if (i_q == KW'(K - 1)) begin
                    i_d = '0;
                    if (c_q == CW'(OUT_W - 1)) begin
                        c_d = '0;
                        if (r_q == RW'(OUT_H - 1)) r_d = '0;
                        else                       r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    assign last_addr = (state_q == ST_RUN) &&
                       (r_q == RW'(OUT_H - 1)) && (c_q == CW'(OUT_W - 1)) &&
                       (i_q == KW'(K - 1)) && (j_q == KW'(K - 1));

    // First tap of each pixel triggers that pixel's whole downstream schedule.
    assign ks_src = (state_q == ST_RUN) && (i_q == '0) && (j_q == '0);

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_RUN;
            ST_RUN:   if (last_addr) state_d = ST_DRAIN;
            ST_DRAIN: if (wr_last)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Read addresses are pure functions of the counters while RUN.
    always_comb begin
        in_fm_rd_ena   = (state_q == ST_RUN);
        weight_rd_ena  = (state_q == ST_RUN);
        in_fm_rd_addr  = '0;
        weight_rd_addr = '0;
        if (state_q == ST_RUN) begin
            in_fm_rd_addr  = AW'((32'(r_q) + 32'(i_q)) * IN_W + 32'(c_q) + 32'(j_q));
            weight_rd_addr = WAW'(32'(i_q) * K + 32'(j_q));
        end
    end

    sig_delay #(.DELAY(MEM_DELAY)) u_ks_dly (
        .clk_i   (clk),
        .rst_n_i (rst),
        .d_i     (ks_src),
        .q_o     (kernel_start)
    );

    sig_delay #(.DELAY(ACC_DELAY - MEM_DELAY)) u_rd_dly (
        .clk_i   (clk),
        .rst_n_i (rst),
        .d_i     (kernel_start),
        .q_o     (rd_pulse)
    );

    sig_delay #(.DELAY(ACC_DELAY + FP_ADD_DELAY)) u_wr_dly (
        .clk_i   (clk),
        .rst_n_i (rst),
        .d_i     (kernel_start),
        .q_o     (wr_pulse)
    );

    // Pixels complete in issue order, so the out_fm read and write sides each
    // keep their own pixel index and step it on their own pulse.
    always_comb begin
        rd_pix_d = rd_pix_q;
        wr_pix_d = wr_pix_q;
        if (rd_pulse) rd_pix_d = (rd_pix_q == AW'(NPIX - 1)) ? '0 : rd_pix_q + 1'b1;
        if (wr_pulse) wr_pix_d = (wr_pix_q == AW'(NPIX - 1)) ? '0 : wr_pix_q + 1'b1;
    end

    assign wr_last = wr_pulse && (wr_pix_q == AW'(NPIX - 1));
    assign done_d  = wr_last;

    assign out_fm_rd_ena  = rd_pulse;
    assign out_fm_rd_addr = rd_pulse ? rd_pix_q : '0;
    assign out_fm_wr_ena  = wr_pulse;
    assign out_fm_wr_addr = wr_pulse ? wr_pix_q : '0;
    assign done           = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            rd_pix_q <= '0;
            wr_pix_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            i_q      <= i_d;
            j_q      <= j_d;
            rd_pix_q <= rd_pix_d;
            wr_pix_q <= wr_pix_d;
            done_q   <= done_d;
        end
    end

endmodule
